// File: rtl/his_peak_finder_if.sv
// ---------------------------------------------------------------------------
// his_peak_finder_if
// Bundles the two handshakes around the histogram peak finder:
//   bin stream  : bin_valid/bin_ready, bin_count, bin_last, hist_sel, thr
//   result      : res_valid/res_ready, peak_bin, peak_cnt, total_cnt,
//                 detect, frame_err, res_bank, pixel_idx
// Modports:
//   master : environment view (drives bins, consumes results)
//   slave  : peak finder view (consumes bins, drives results)
// ---------------------------------------------------------------------------
interface his_peak_finder_if #(
   parameter int NB    = 8,
   parameter int CNT_W = 16,
   parameter int PIX_W = 8
);
   logic                  bin_valid;
   logic                  bin_ready;
   logic [CNT_W-1:0]      bin_count;
   logic                  bin_last;
   logic                  hist_sel;
   logic [CNT_W-1:0]      thr;
   logic                  res_valid;
   logic                  res_ready;
   logic [NB-1:0]         peak_bin;
   logic [CNT_W-1:0]      peak_cnt;
   logic [CNT_W+NB-1:0]   total_cnt;
   logic                  detect;
   logic                  frame_err;
   logic                  res_bank;
   logic [PIX_W-1:0]      pixel_idx;

   modport master (
      output bin_valid, bin_count, bin_last, hist_sel, thr, res_ready,
      input  bin_ready, res_valid, peak_bin, peak_cnt, total_cnt,
             detect, frame_err, res_bank, pixel_idx
   );

   modport slave (
      input  bin_valid, bin_count, bin_last, hist_sel, thr, res_ready,
      output bin_ready, res_valid, peak_bin, peak_cnt, total_cnt,
             detect, frame_err, res_bank, pixel_idx
   );
endinterface

// File: rtl/his_peak_finder.sv
// ---------------------------------------------------------------------------
// his_peak_finder
// Scans one pixel histogram (bin counts streamed in bin order) and emits one
// record per histogram: peak bin/count (ties keep the lowest index), total
// count, threshold detection, frame-length error, bank echo and pixel index.
// Ports:
//   clk  : rising-edge clock
//   res  : asynchronous active-high reset
//   bus  : his_peak_finder_if.slave (bin stream in, result record out)
// ---------------------------------------------------------------------------
module his_peak_finder #(
   parameter int NB        = 8,
   parameter int NUM_BINS  = 256,
   parameter int CNT_W     = 16,
   parameter int PIXEL_NUM = 200,
   parameter int PIX_W     = 8
) (
   input  logic               clk,
   input  logic               res,
   his_peak_finder_if.slave   bus
);

   localparam logic [NB:0]      LAST_IDX = (NB+1)'(NUM_BINS - 1);
   localparam logic [NB:0]      IDX_ONE  = (NB+1)'(1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXEL_NUM - 1);
   localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);

   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

   state_t                state, state_nxt;
   logic                  ready_q;
   logic [NB:0]           idx_p0;
   logic [CNT_W-1:0]      max_cnt_p0;
   logic [NB-1:0]         max_idx_p0;
   logic [CNT_W+NB-1:0]   sum_p0;
   logic [CNT_W-1:0]      thr_p0;
   logic                  bank_p0;

   logic                  accept;
   logic                  first_bin;
   logic                  at_last_idx;
   logic                  end_bin;
   logic                  res_fire;
   logic [CNT_W-1:0]      max_cnt_nxt;
   logic [NB-1:0]         max_idx_nxt;
   logic [CNT_W+NB-1:0]   sum_nxt;
   logic [CNT_W-1:0]      thr_eff;
   logic                  bank_eff;

   // ready_q keeps bin_ready low until the first clock after reset release
   assign bus.bin_ready = ready_q & (state != HOLD);
   assign bus.res_valid = (state == HOLD);

   assign accept      = bus.bin_valid & bus.bin_ready;
   assign first_bin   = (state == IDLE);
   // idx_p0 is 0 in IDLE, so it is the index of the bin being accepted
   assign at_last_idx = (idx_p0 == LAST_IDX);
   assign end_bin     = accept & (bus.bin_last | at_last_idx);
   assign res_fire    = bus.res_valid & bus.res_ready;

   // Accumulator update for the bin presented this cycle; the first bin
   // restarts max/sum and takes threshold and bank from the live inputs.
   always_comb begin
      max_cnt_nxt = max_cnt_p0;
      max_idx_nxt = max_idx_p0;
      sum_nxt     = sum_p0 + {{NB{1'b0}}, bus.bin_count};
      thr_eff     = thr_p0;
      bank_eff    = bank_p0;
      if (first_bin) begin
         max_cnt_nxt = bus.bin_count;
         max_idx_nxt = '0;
         sum_nxt     = {{NB{1'b0}}, bus.bin_count};
         thr_eff     = bus.thr;
         bank_eff    = bus.hist_sel;
      end else if (bus.bin_count > max_cnt_p0) begin
         // strict compare: an equal later bin never displaces the earlier one
         max_cnt_nxt = bus.bin_count;
         max_idx_nxt = idx_p0[NB-1:0];
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)   state_nxt = end_bin ? HOLD : SCAN;
         SCAN:    if (end_bin)  state_nxt = HOLD;
         HOLD:    if (res_fire) state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Stage p0: per-bin accumulation; result registers load on the end bin
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         ready_q       <= 1'b0;
         idx_p0        <= '0;
         max_cnt_p0    <= '0;
         max_idx_p0    <= '0;
         sum_p0        <= '0;
         thr_p0        <= '0;
         bank_p0       <= 1'b0;
         bus.peak_bin  <= '0;
         bus.peak_cnt  <= '0;
         bus.total_cnt <= '0;
         bus.detect    <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.res_bank  <= 1'b0;
         bus.pixel_idx <= '0;
      end else begin
         ready_q <= 1'b1;
         if (accept) begin
            idx_p0     <= end_bin ? '0 : idx_p0 + IDX_ONE;
            max_cnt_p0 <= max_cnt_nxt;
            max_idx_p0 <= max_idx_nxt;
            sum_p0     <= sum_nxt;
            thr_p0     <= thr_eff;
            bank_p0    <= bank_eff;
         end
         // No bin can be accepted in HOLD, so the record is frozen there
         if (end_bin) begin
            bus.peak_bin  <= max_idx_nxt;
            bus.peak_cnt  <= max_cnt_nxt;
            bus.total_cnt <= sum_nxt;
            bus.detect    <= (max_cnt_nxt >= thr_eff);
            bus.frame_err <= bus.bin_last ^ at_last_idx;
            bus.res_bank  <= bank_eff;
         end
         if (res_fire) begin
            bus.pixel_idx <= (bus.pixel_idx == PIX_LAST) ? '0 : bus.pixel_idx + PIX_ONE;
         end
      end
   end

endmodule

// File: tb/tb_his_peak_finder.sv
// ---------------------------------------------------------------------------
// tb_his_peak_finder
// Self-checking bench for his_peak_finder: directed vector table, hand-built
// reset/backpressure/wrap sequences and random histograms against a
// reference model computed directly from the bin array.
// ---------------------------------------------------------------------------
module tb_his_peak_finder;
   localparam int NB        = 8;
   localparam int NUM_BINS  = 256;
   localparam int CNT_W     = 16;
   localparam int PIXEL_NUM = 200;
   localparam int PIX_W     = 8;

   logic clk = 1'b0;
   logic res;
   always #5 clk = ~clk;

   his_peak_finder_if #(.NB(NB), .CNT_W(CNT_W), .PIX_W(PIX_W)) bus ();

   his_peak_finder #(
      .NB(NB), .NUM_BINS(NUM_BINS), .CNT_W(CNT_W),
      .PIXEL_NUM(PIXEL_NUM), .PIX_W(PIX_W)
   ) dut (
      .clk(clk),
      .res(res),
      .bus(bus)
   );

   typedef struct {
      int base; int a; int va; int b; int vb;
      int last_at; int thr; int sel;
      int e_pb; int e_pc; int e_tot; int e_det; int e_fe;
   } vec_t;

   vec_t vecs[10];
   int   cnt[NUM_BINS];
   int   n_chk = 0;
   int   n_err = 0;
   int   exp_pix = 0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic build(input int base, input int a, input int va, input int b, input int vb);
      for (int k = 0; k < NUM_BINS; k++) cnt[k] = base;
      if (a >= 0) cnt[a] = va;
      if (b >= 0) cnt[b] = vb;
   endtask

   // Reference: max value over the frame, then the lowest index holding it.
   function automatic void model(input int last_at, input int thr_v,
                                 output int pb, output int pc, output int tot,
                                 output int det, output int fe);
      int len;
      len = (last_at >= 0 && last_at < NUM_BINS) ? last_at + 1 : NUM_BINS;
      pc = 0; tot = 0; pb = 0;
      for (int k = 0; k < len; k++) begin
         tot += cnt[k];
         if (cnt[k] > pc) pc = cnt[k];
      end
      for (int k = len - 1; k >= 0; k--) if (cnt[k] == pc) pb = k;
      det = (pc >= thr_v) ? 1 : 0;
      fe  = (last_at != NUM_BINS - 1) ? 1 : 0;
   endfunction

   // Called at a negedge; returns at the negedge after the result handshake.
   task automatic run_hist(input string name, input int last_at, input int thr_v,
                           input int sel_v, input int hold,
                           input int e_pb, input int e_pc, input int e_tot,
                           input int e_det, input int e_fe);
      int len, i, guard, bad;
      bit acc, seen;
      logic [58:0] snap;
      len = (last_at >= 0 && last_at < NUM_BINS) ? last_at + 1 : NUM_BINS;
      i = 0; guard = 0;
      while (i < len && guard < 4 * NUM_BINS) begin
         bus.bin_valid = 1'b1;
         bus.bin_count = CNT_W'(cnt[i]);
         bus.bin_last  = (i == last_at);
         bus.hist_sel  = (i == 0) ? sel_v[0] : 1'($urandom);
         bus.thr       = (i == 0) ? CNT_W'(thr_v) : CNT_W'($urandom);
         acc = bus.bin_ready;
         @(posedge clk); @(negedge clk);
         if (acc) i++;
         guard++;
      end
      if (i < len) chk({name, "_bins_accepted"}, i, len);
      bus.bin_valid = 1'b0;
      bus.bin_last  = 1'b0;
      chk({name, "_latency"}, bus.res_valid, 1);
      guard = 0;
      while (!bus.res_valid && guard < 20) begin
         @(posedge clk); @(negedge clk);
         guard++;
      end
      seen = bus.res_valid;
      chk({name, "_peak_bin"},  bus.peak_bin,  e_pb);
      chk({name, "_peak_cnt"},  bus.peak_cnt,  e_pc);
      chk({name, "_total_cnt"}, bus.total_cnt, e_tot);
      chk({name, "_detect"},    bus.detect,    e_det);
      chk({name, "_frame_err"}, bus.frame_err, e_fe);
      chk({name, "_res_bank"},  bus.res_bank,  sel_v);
      chk({name, "_pixel_idx"}, bus.pixel_idx, exp_pix);
      snap = {bus.peak_bin, bus.peak_cnt, bus.total_cnt, bus.detect,
              bus.frame_err, bus.res_bank, bus.pixel_idx};
      bad = 0;
      for (int h = 0; h < hold; h++) begin
         bus.bin_valid = 1'b1;
         bus.bin_count = CNT_W'($urandom);
         bus.bin_last  = 1'($urandom);
         @(posedge clk); @(negedge clk);
         if (snap != {bus.peak_bin, bus.peak_cnt, bus.total_cnt, bus.detect,
                      bus.frame_err, bus.res_bank, bus.pixel_idx}) bad++;
         if (bus.res_valid !== 1'b1 || bus.bin_ready !== 1'b0) bad++;
      end
      if (hold > 0) chk({name, "_hold_stable"}, bad, 0);
      bus.bin_valid = 1'b0;
      bus.bin_last  = 1'b0;
      bus.res_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.res_ready = 1'b0;
      if (seen) exp_pix = (exp_pix + 1) % PIXEL_NUM;
      chk({name, "_released"}, bus.res_valid, 0);
      chk({name, "_ready_again"}, bus.bin_ready, 1);
   endtask

   task automatic apply_vec(input string name, input int v, input int hold);
      build(vecs[v].base, vecs[v].a, vecs[v].va, vecs[v].b, vecs[v].vb);
      run_hist(name, vecs[v].last_at, vecs[v].thr, vecs[v].sel, hold,
               vecs[v].e_pb, vecs[v].e_pc, vecs[v].e_tot, vecs[v].e_det, vecs[v].e_fe);
   endtask

   task automatic run_random(input string name, input int last_at, input int hold);
      int pb, pc, tot, det, fe, thr_v, sel_v;
      sel_v = int'($urandom_range(0, 1));
      thr_v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 65535));
      model(last_at, thr_v, pb, pc, tot, det, fe);
      run_hist(name, last_at, thr_v, sel_v, hold, pb, pc, tot, det, fe);
   endtask

   initial begin
      int i, guard, spur, last_at, mode, pb, pc, tot, det, fe;
      bit acc;
      //           base  a   va   b    vb  last thr   sel  pb   pc    tot    det fe
      vecs[0] = '{3,     37, 500, -1,  0,  255, 0,    0,   37,  500,  1265,  1,  0};
      vecs[1] = '{0,     10, 900, 200, 900,255, 900,  1,   10,  900,  1800,  1,  0};
      vecs[2] = '{0,     10, 900, 200, 900,255, 901,  0,   10,  900,  1800,  0,  0};
      vecs[3] = '{1,     50, 7,   -1,  0,  99,  8,    1,   50,  7,    106,   0,  1};
      vecs[4] = '{2,     255,9,   -1,  0,  -1,  9,    0,   255, 9,    519,   1,  1};
      vecs[5] = '{1,     -1, 0,   -1,  0,  255, 2,    1,   0,   1,    256,   0,  0};
      vecs[6] = '{65535, -1, 0,   -1,  0,  255, 65535,0,   0,   65535,16776960,1, 0};
      vecs[7] = '{0,     0,  42,  -1,  0,  0,   42,   1,   0,   42,   42,    1,  1};
      vecs[8] = '{0,     -1, 0,   -1,  0,  255, 0,    1,   0,   0,    0,     1,  0};
      vecs[9] = '{0,     0,  50,  255, 50, 255, 51,   0,   0,   50,   100,   0,  0};

      res = 1'b1;
      bus.bin_valid = 1'b0; bus.bin_count = '0; bus.bin_last = 1'b0;
      bus.hist_sel = 1'b0;  bus.thr = '0;       bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_bin_ready", bus.bin_ready, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_pixel_idx", bus.pixel_idx, 0);
      res = 1'b0;
      @(negedge clk);
      chk("rel_bin_ready", bus.bin_ready, 1);

      for (int v = 0; v < 10; v++) apply_vec($sformatf("vec%0d", v), v, 0);

      // backpressure: record held 20 cycles, then next histogram back-to-back
      build(5, 128, 1000, -1, 0);
      run_hist("bp", 255, 1000, 1, 20, 128, 1000, 2275, 1, 0);
      apply_vec("bp_next", 5, 0);

      for (int k = 0; k < 30; k++) begin
         mode = int'($urandom_range(0, 3));
         for (int j = 0; j < NUM_BINS; j++)
            cnt[j] = (mode[0]) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 65535));
         case (mode)
            0: last_at = 255;
            1: last_at = -1;
            2: last_at = int'($urandom_range(0, 254));
            default: last_at = int'($urandom_range(0, 15));
         endcase
         run_random($sformatf("rnd%0d", k), last_at, int'($urandom_range(0, 3)));
      end

      // reset in the middle of a scan: outputs clear at once, no record
      apply_vec("pre_rst", 3, 0);
      build(7, -1, 0, -1, 0);
      i = 0; guard = 0;
      while (i < 100 && guard < 400) begin
         bus.bin_valid = 1'b1; bus.bin_count = 16'd7; bus.bin_last = 1'b0;
         acc = bus.bin_ready;
         @(posedge clk); @(negedge clk);
         if (acc) i++;
         guard++;
      end
      res = 1'b1;
      #1;
      chk("mid_rst_res_valid", bus.res_valid, 0);
      chk("mid_rst_bin_ready", bus.bin_ready, 0);
      chk("mid_rst_peak_bin",  bus.peak_bin,  0);
      chk("mid_rst_peak_cnt",  bus.peak_cnt,  0);
      chk("mid_rst_total_cnt", bus.total_cnt, 0);
      chk("mid_rst_frame_err", bus.frame_err, 0);
      chk("mid_rst_res_bank",  bus.res_bank,  0);
      chk("mid_rst_pixel_idx", bus.pixel_idx, 0);
      bus.bin_valid = 1'b0;
      @(negedge clk);
      res = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready_after", bus.bin_ready, 1);
      spur = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.res_valid) spur++;
      end
      chk("mid_rst_no_record", spur, 0);
      exp_pix = 0;
      apply_vec("post_rst", 0, 0);

      // pixel wrap and bank echo over 201 back-to-back short histograms
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      @(negedge clk);
      exp_pix = 0;
      for (int k = 0; k < 201; k++) begin
         for (int j = 0; j < 8; j++) cnt[j] = int'($urandom_range(0, 65535));
         last_at = int'($urandom_range(0, 5));
         model(last_at, 1000, pb, pc, tot, det, fe);
         run_hist($sformatf("wrap%0d", k), last_at, 1000, k % 2, 0, pb, pc, tot, det, fe);
      end
      chk("wrap_final_pixel", bus.pixel_idx, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/his_peak_finder.md
# his_peak_finder

Downstream consumer of the histogram builder. Accepts one pixel's histogram as a stream of bin counts, in bin order, from the active ping-pong bank. Produces one result record per histogram:
- peak bin index and peak count;
- total photon count;
- detection flag against a programmable threshold;
- pixel index.

Results go to the depth/ToF conversion stage over a valid/ready handshake.

## Interface
Parameters:
- NB, 8 — bin index width; also the width of the builder's addr.
- NUM_BINS, 256 — bins per histogram; must be ≤ 2^NB.
- CNT_W, 16 — width of one bin count.
- PIXEL_NUM, 200 — pixels per RAM pass; the pixel index wraps after this value.
- PIX_W, 8 — pixel index width.

Ports (clock and reset first):
- clk, input, 1 — single clock; all logic is on the rising edge.
- res, input, 1 — asynchronous, active-high reset.
- bin_valid, input, 1 — bin_count is valid.
- bin_ready, output, 1 — block can accept a bin.
- bin_count, input, CNT_W — count of the current bin.
- bin_last, input, 1 — this bin is the last of the histogram.
- hist_sel, input, 1 — bank id (the hisNum of the builder), sampled on the first bin.
- thr, input, CNT_W — detection threshold, sampled on the first bin.
- res_valid, output, 1 — result record valid.
- res_ready, input, 1 — downstream accepts the record.
- peak_bin, output, NB — index of the maximum bin.
- peak_cnt, output, CNT_W — count at peak_bin.
- total_cnt, output, CNT_W+NB — sum of all accepted bins.
- detect, output, 1 — 1 when peak_cnt ≥ sampled thr.
- frame_err, output, 1 — histogram length did not match NUM_BINS.
- res_bank, output, 1 — sampled hist_sel.
- pixel_idx, output, PIX_W — pixel number of this record.

## Operation
States and transitions:
- IDLE → SCAN on the first accepted bin.
- SCAN → HOLD on the end-of-histogram bin.
- HOLD → IDLE on res_valid & res_ready.

Input acceptance:
- bin_ready = 1 in IDLE and SCAN; 0 in HOLD.
- A bin is accepted when bin_valid & bin_ready.

Accumulation:
- Internal bin index idx (NB+1 bits) is 0 on the first bin and increments on every accepted bin.
- On the first bin:
  - max_cnt ← bin_count, max_idx ← 0, sum ← bin_count;
  - thr and hist_sel are latched.
- On each later bin:
  - sum ← sum + bin_count (exact width, no saturation);
  - if bin_count > max_cnt (strictly greater), max_cnt ← bin_count and max_idx ← idx.
- Ties therefore keep the lowest index.

End of histogram and frame error:
- End is the accepted bin with bin_last = 1 OR idx = NUM_BINS−1.
- frame_err = bin_last XOR (idx = NUM_BINS−1), evaluated on that bin.
- An early bin_last gives a short frame; a missing bin_last gives a forced end at NUM_BINS.
- The end bin itself is included in max and sum.

Result record:
- On entering HOLD, all result outputs are registered and stay stable until the handshake completes.
- detect = (peak_cnt ≥ latched thr). thr = 0 always detects.

Pixel index:
- pixel_idx increments on each completed result handshake.
- It wraps PIXEL_NUM−1 → 0.
- It is not reset by frame_err.

Reset:
- res clears to 0 immediately and asynchronously: state (→ IDLE), idx, max_cnt, max_idx, sum, pixel_idx and all outputs.
- A histogram in progress when res asserts is discarded; no record is produced.
- Reset values: bin_ready 0 while res = 1, then 1 in the first cycle after release.

## Timing
- Throughput: one bin per cycle in SCAN with no bubbles.
- Result latency: res_valid rises in the cycle after the end bin is accepted (latency 1).
- Handshake:
  - res_valid stays high until res_ready.
  - Record fields must not change while res_valid = 1.
- Back-to-back histograms:
  - if res_ready is held high, the record completes in its first HOLD cycle and IDLE follows the next cycle;
  - minimum gap between the end bin of one histogram and the first bin of the next is 2 cycles.
- Bins presented during HOLD are not accepted (bin_ready = 0); upstream must hold them.
- Single-bin histogram (first bin with bin_last = 1): SCAN is skipped, IDLE → HOLD directly, with peak_bin = 0.

## Test plan
- Reset: assert res mid-SCAN at bin 100 → next cycle all outputs are 0, state is IDLE, no record. Then 256 bins with bin 37 = 500 and all others 3 → peak_bin = 37, peak_cnt = 500, total_cnt = 1265, frame_err = 0, pixel_idx = 0.
- Tie and threshold: bins 10 and 200 both = 900, others 0, thr = 900 → peak_bin = 10, detect = 1. Rerun with thr = 901 → detect = 0.
- Frame errors:
  - bin_last at idx 99 → record after bin 99, frame_err = 1;
  - no bin_last through 256 bins → forced end at bin 255, frame_err = 1;
  - next histogram is normal → frame_err = 0.
- Backpressure: hold res_ready = 0 for 20 cycles → record stable, bin_ready = 0, bins held by upstream. Then res_ready = 1 → one handshake, next histogram is accepted 2 cycles after its end bin.
- Overflow width: all 256 bins = 0xFFFF → total_cnt = 0xFFFF00 exact, peak_bin = 0.
- Pixel wrap and bank echo: 201 back-to-back histograms with hist_sel toggling each one → pixel_idx runs 0..199 then 0, and res_bank matches each hist_sel.
